alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU stage feeding the accumulator register.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL, DIV by zero) finish one cycle
// after the accepting edge; MUL and DIV iterate one bit per clock for
// WIDTH clocks. result and flags are registered and change only when an
// operation completes, so the accumulator sees a stable value meanwhile.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             divz
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] DW_ZERO = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Outcome of a single-cycle operation.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             divz;
    } sc_t;

    // Combinational evaluation of every op that completes in one cycle.
    // DIV only reaches this path when the divisor is zero.
    function automatic sc_t single_op(input logic [2:0]       f_op,
                                      input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
        sc_t            r;
        logic [WIDTH:0] wide;
        r    = '{res: W_ZERO, carry: 1'b0, ovf: 1'b0, divz: 1'b0};
        wide = {(WIDTH+1){1'b0}};
        case (f_op)
            OP_ADD: begin
                wide    = {1'b0, x} + {1'b0, y};
                r.res   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
                r.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (wide[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                wide    = {1'b0, x} - {1'b0, y};
                r.res   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
                r.ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (wide[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: r.res = x & y;
            OP_OR:  r.res = x | y;
            OP_XOR: r.res = x ^ y;
            OP_SHL: begin
                // One extra bit above the result catches the last bit out.
                wide    = {1'b0, x} << y[3:0];
                r.res   = wide[WIDTH-1:0];
                r.carry = (y[3:0] == 4'd0) ? 1'b0 : wide[WIDTH];
            end
            OP_DIV: begin
                r.res  = W_ONES;
                r.divz = 1'b1;
            end
            default: begin
                r.res = W_ZERO;
            end
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               divz_q, divz_d;

    logic [2*WIDTH-1:0] mul_add_s;
    logic [2*WIDTH-1:0] mul_sum_s;
    logic [WIDTH:0]     rem_shift_s;
    logic               div_fit_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    sc_t                sc_s;

    // Shift-add multiply step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        mul_add_s = mplier_q[0] ? mcand_q : DW_ZERO;
        mul_sum_s = prod_q + mul_add_s;
    end

    // Restoring divide step: bring in the next dividend bit, subtract the
    // divisor only if it fits. The W-bit wrap-around difference is exact
    // whenever the subtraction is taken.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        div_fit_s   = (rem_shift_s >= {1'b0, dvsr_q});
        div_diff_s  = rem_shift_s[WIDTH-1:0] - dvsr_q;
        if (div_fit_s) begin
            rem_next_s = div_diff_s;
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
        end
        quo_next_s = {quo_q[WIDTH-2:0], div_fit_s};
    end

    // Next-state logic for the FSM, iteration registers and result/flags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        divz_d   = divz_q;
        sc_s     = single_op(op, a, b);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((op == OP_MUL) || ((op == OP_DIV) && (b != W_ZERO))) begin
                        // Capture operands into the iteration registers so
                        // later input changes cannot disturb the op.
                        state_d  = ST_EXEC;
                        cnt_d    = CNT_ZERO;
                        is_div_d = (op == OP_DIV);
                        mcand_d  = {W_ZERO, a};
                        mplier_d = b;
                        prod_d   = DW_ZERO;
                        quo_d    = a;
                        rem_d    = W_ZERO;
                        dvsr_d   = b;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = sc_s.res;
                        zero_d   = (sc_s.res == W_ZERO);
                        carry_d  = sc_s.carry;
                        ovf_d    = sc_s.ovf;
                        divz_d   = sc_s.divz;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                cnt_d = cnt_q + CNT_ONE;
                if (is_div_q) begin
                    quo_d = quo_next_s;
                    rem_d = rem_next_s;
                end else begin
                    prod_d   = mul_sum_s;
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    // Final iteration: publish result and flags together.
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                    carry_d = 1'b0;
                    divz_d  = 1'b0;
                    if (is_div_q) begin
                        result_d = quo_next_s;
                        zero_d   = (quo_next_s == W_ZERO);
                        ovf_d    = 1'b0;
                    end else begin
                        result_d = mul_sum_s[WIDTH-1:0];
                        zero_d   = (mul_sum_s[WIDTH-1:0] == W_ZERO);
                        ovf_d    = (mul_sum_s[2*WIDTH-1:WIDTH] != W_ZERO);
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            is_div_q <= 1'b0;
            mcand_q  <= DW_ZERO;
            mplier_q <= W_ZERO;
            prod_q   <= DW_ZERO;
            quo_q    <= W_ZERO;
            rem_q    <= W_ZERO;
            dvsr_q   <= W_ZERO;
            result_q <= W_ZERO;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            divz_q   <= divz_d;
        end
    end

    // busy/done decode straight from the state register, so they are glitch-free.
    always_comb begin
        result = result_q;
        busy   = (state_q == ST_EXEC);
        done   = (state_q == ST_DONE);
        zero   = zero_q;
        carry  = carry_q;
        ovf    = ovf_q;
        divz   = divz_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        divz;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] prev_r;

    alu_seq #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done),
        .zero   (zero),
        .carry  (carry),
        .ovf    (ovf),
        .divz   (divz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic. lat is the number of cycles
    // from the accepting edge to the cycle in which done is high.
    function automatic void ref_model(input logic [2:0] f_op, input logic [15:0] fa, input logic [15:0] fb,
                                      output logic [15:0] r, output logic c, output logic v,
                                      output logic dz, output int lat);
        int         sa, sb, s, n;
        longint     p;
        sa  = int'($signed(fa));
        sb  = int'($signed(fb));
        r   = 16'h0000;
        c   = 1'b0;
        v   = 1'b0;
        dz  = 1'b0;
        lat = 1;
        case (f_op)
            3'd0: begin
                s = int'(fa) + int'(fb);
                r = s[15:0];
                c = (s > 65535);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            3'd1: begin
                s = int'(fa) - int'(fb);
                r = s[15:0];
                c = (fa < fb);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            3'd2: r = fa & fb;
            3'd3: r = fa | fb;
            3'd4: r = fa ^ fb;
            3'd5: begin
                n = int'(fb[3:0]);
                p = longint'(fa) << n;
                r = p[15:0];
                c = (n == 0) ? 1'b0 : fa[16-n];
            end
            3'd6: begin
                p   = longint'(fa) * longint'(fb);
                r   = p[15:0];
                v   = (p > 65535);
                lat = 17;
            end
            default: begin
                if (fb == 16'h0000) begin
                    r  = 16'hFFFF;
                    dz = 1'b1;
                end else begin
                    r   = fa / fb;
                    lat = 17;
                end
            end
        endcase
    endfunction

    // Issue one op at the current negedge and check timing and results.
    // With noise set, start is held high with random ops while busy/done.
    task automatic run_op(input logic [2:0] t_op, input logic [15:0] ta, input logic [15:0] tb_v,
                          input bit noise, input string tag);
        logic [15:0] er;
        logic        ec, ev, edz;
        int          lat, got_at;
        bit          multi;
        ref_model(t_op, ta, tb_v, er, ec, ev, edz, lat);
        multi  = (lat == 17);
        start  = 1'b1;
        op     = t_op;
        a      = ta;
        b      = tb_v;
        got_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (multi && k == 1) check_eq({tag, ".hold"}, result, prev_r);
            if (k <= lat) check_eq({tag, ".busy"}, busy, (multi && k < lat));
            if (done === 1'b1) begin
                got_at = k;
                break;
            end
            start = noise;
            op    = 3'($urandom);
            a     = 16'($urandom);
            b     = 16'($urandom);
        end
        start = 1'b0;
        check_eq({tag, ".lat"},   got_at, lat);
        check_eq({tag, ".res"},   result, er);
        check_eq({tag, ".zero"},  zero,   (er == 16'h0000));
        check_eq({tag, ".carry"}, carry,  ec);
        check_eq({tag, ".ovf"},   ovf,    ev);
        check_eq({tag, ".divz"},  divz,   edz);
        prev_r = er;
        @(negedge clk);
        check_eq({tag, ".done_w"}, done, 1'b0);
        check_eq({tag, ".idle"},   busy, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".res"},   result, 16'h0000);
        check_eq({tag, ".busy"},  busy,   1'b0);
        check_eq({tag, ".done"},  done,   1'b0);
        check_eq({tag, ".zero"},  zero,   1'b1);
        check_eq({tag, ".carry"}, carry,  1'b0);
        check_eq({tag, ".ovf"},   ovf,    1'b0);
        check_eq({tag, ".divz"},  divz,   1'b0);
    endtask

    initial begin
        int          dones;
        logic [2:0]  r_op;
        logic [15:0] r_a, r_b;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a      = 16'h0000;
        b      = 16'h0000;
        prev_r = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // Directed corner cases.
        run_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        run_op(3'd1, 16'h0000, 16'h0001, 1'b0, "sub_borrow");
        run_op(3'd6, 16'h0100, 16'h0101, 1'b0, "mul_ovf");
        run_op(3'd7, 16'd100,  16'd7,    1'b0, "div_100_7");
        run_op(3'd7, 16'd5,    16'h0000, 1'b0, "div_zero");
        run_op(3'd5, 16'h8001, 16'hFFF0, 1'b0, "shl_0");
        run_op(3'd5, 16'h8001, 16'h0001, 1'b0, "shl_1");
        run_op(3'd5, 16'h0001, 16'h000F, 1'b0, "shl_15");
        run_op(3'd6, 16'h1234, 16'h0002, 1'b1, "mul_noise");
        run_op(3'd2, 16'hF0F0, 16'h0F0F, 1'b0, "and_zero");

        // Reset on the 8th EXEC cycle of a DIV.
        start = 1'b1;
        op    = 3'd7;
        a     = 16'd100;
        b     = 16'd7;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 8) reset = 1'b1;
        end
        @(negedge clk);
        check_reset_vals("rst_exec");
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check_eq("rst_exec.no_done", dones, 0);
        prev_r = 16'h0000;
        run_op(3'd0, 16'h1111, 16'h2222, 1'b0, "add_after_rst");

        // Random operations.
        for (int i = 0; i < 150; i++) begin
            r_op = 3'($urandom);
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: r_a = 16'h7FFF;
                1: r_a = 16'h8000;
                2: r_b = 16'hFFFF;
                3: r_b = 16'($urandom_range(0, 3));
                default: r_a = r_a;
            endcase
            if (r_op == 3'd6 && r_b == 16'h0000) r_b = 16'h0001;
            if (r_op == 3'd7 && $urandom_range(0, 7) == 0) r_b = 16'h0000;
            run_op(r_op, r_a, r_b, ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
